serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/addsub_pkg.sv | 15 +
 rtl/fa_cell.sv | 22 ++
 rtl/serial_addsub.sv | 103 ++++++++++
 tb/tb_serial_addsub.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   OP_ADD / OP_SUB : encodings of the op input
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from gate primitives.
//   x, y : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p, g, t;

  xor u_p  (p, x, y);
  xor u_s  (s, p, cin);
  and u_g  (g, x, y);
  and u_t  (t, p, cin);
  or  u_co (cout, g, t);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, one bit per cycle, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an operation (honoured only in IDLE)
//   op         : OP_ADD -> a+b+c, OP_SUB -> a-b-c
//   a, b, c    : operands and carry/borrow-in, latched on the start edge
//   busy       : high while bits are being shifted
//   done       : one-cycle pulse when sum/carry carry a fresh result
//   sum, carry : result and carry-out (borrow-out for subtract), held
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             cy, op_r;
  logic             y_bit, fa_s, fa_co;

  // Subtract runs a + ~b + ~c through the same cell: b is inverted bit by
  // bit here, and ~c is folded into the initial serial carry.
  assign y_bit = b_sr[0] ^ (op_r == OP_SUB);

  fa_cell u_fa (
    .x    (a_sr[0]),
    .y    (y_bit),
    .cin  (cy),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cy     <= 1'b0;
      op_r   <= OP_ADD;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op_r  <= op;
            cy    <= (op == OP_SUB) ? ~c : c;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cy     <= fa_co;
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Final bit: publish the result; borrow is the inverted carry.
            sum   <= {fa_s, res_sr[WIDTH-1:1]};
            carry <= fa_co ^ (op_r == OP_SUB);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4).
module tb_serial_addsub;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         c = 1'b0;
  logic         busy, done, carry;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;
  int prev_sum = 0;
  int prev_carry = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    int           exp_sum;
    int           exp_carry;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference from the arithmetic definition: {carry,sum} of a+b+c, or
  // (a-b-c) mod 2^W with borrow when a < b+c.
  function automatic void model(input int o, input int x, input int y, input int ci,
                                output int s, output int co);
    int r;
    if (o == 0) begin
      r  = x + y + ci;
      s  = r % (1 << W);
      co = r / (1 << W);
    end else begin
      r  = x - y - ci;
      s  = (r + (1 << (W + 1))) % (1 << W);
      co = (x < y + ci) ? 1 : 0;
    end
  endfunction

  // Issue one op; call away from a rising edge. Inputs are scrambled right
  // after the start edge to show they are not looked at again.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input int es, input int ec, input string tag);
    op = o; a = x; b = y; c = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 1'($urandom); a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    for (int n = 1; n <= W + 2; n++) begin
      @(negedge clk);
      if (n <= W) begin
        chk({tag, " busy"}, int'(busy), 1);
        chk({tag, " done_early"}, int'(done), 0);
        chk({tag, " sum_hold"}, int'(sum), prev_sum);
      end else if (n == W + 1) begin
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " busy_off"}, int'(busy), 0);
        chk({tag, " sum"}, int'(sum), es);
        chk({tag, " carry"}, int'(carry), ec);
      end else begin
        chk({tag, " done_pulse"}, int'(done), 0);
        chk({tag, " sum_keep"}, int'(sum), es);
      end
    end
    prev_sum = es;
    prev_carry = ec;
  endtask

  vec_t vt[$];

  initial begin
    int es, ec, n, ndone;

    vt.push_back('{1'b0, 4'd3,  4'd5,  1'b1, 9,  0});
    vt.push_back('{1'b0, 4'd15, 4'd1,  1'b0, 0,  1});
    vt.push_back('{1'b0, 4'd15, 4'd15, 1'b1, 15, 1});
    vt.push_back('{1'b1, 4'd5,  4'd3,  1'b0, 2,  0});
    vt.push_back('{1'b1, 4'd0,  4'd1,  1'b0, 15, 1});
    vt.push_back('{1'b1, 4'd7,  4'd7,  1'b1, 15, 1});
    vt.push_back('{1'b1, 4'd9,  4'd2,  1'b1, 6,  0});

    // Reset state
    #12;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst sum", int'(sum), 0);
    chk("rst carry", int'(carry), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].exp_sum, vt[i].exp_carry,
             $sformatf("vec%0d", i));
    end

    // Start pulsed during the 2nd SHIFT cycle must be ignored
    @(posedge clk); #1;
    op = 1'b0; a = 4'd3; b = 4'd5; c = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 1'b1; a = 4'd1; b = 4'd12; c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 2 * W + 6; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("busy_start sum", int'(sum), 9);
        chk("busy_start carry", int'(carry), 0);
      end
    end
    chk("busy_start done_count", ndone, 1);
    chk("busy_start idle", int'(busy), 0);
    prev_sum = 9;

    // Reset during the 3rd SHIFT cycle
    @(posedge clk); #1;
    op = 1'b0; a = 4'd6; b = 4'd7; c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst sum", int'(sum), 0);
    chk("midrst carry", int'(carry), 0);
    repeat (W + 2) begin
      @(negedge clk);
      chk("midrst no_done", int'(done), 0);
    end
    prev_sum = 0;
    // Start already high on the first edge with rst_n=1
    rst_n = 1'b1;
    run_op(1'b0, 4'd1, 4'd1, 1'b0, 2, 0, "post_rst");

    // Exhaustive, back-to-back with start held high
    @(posedge clk); #1;
    {op, c, b, a} = '0;
    start = 1'b1;
    for (int i = 0; i < (1 << (2 * W + 2)); i++) begin
      model(int'(op), int'(a), int'(b), int'(c), es, ec);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < W + 4);
      chk("exh latency", n, W + 2);
      chk("exh sum", int'(sum), es);
      chk("exh carry", int'(carry), ec);
      if (i == (1 << (2 * W + 2)) - 1) start = 1'b0;
      else {op, c, b, a} = (2 * W + 2)'(i + 1);
    end
    prev_sum = es;
    @(posedge clk);
    @(posedge clk); #1;
    chk("exh stop", int'(busy), 0);

    // Random ops with random idle gaps
    for (int i = 0; i < 150; i++) begin
      logic o, ci;
      logic [W-1:0] x, y;
      o = 1'($urandom); ci = 1'($urandom);
      x = W'($urandom); y = W'($urandom);
      model(int'(o), int'(x), int'(y), int'(ci), es, ec);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      run_op(o, x, y, ci, es, ec, "rnd");
    end
    repeat (3) @(negedge clk);
    chk("final hold sum", int'(sum), prev_sum);
    chk("final hold carry", int'(carry), prev_carry);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
